port_arb: RTL and testbench

PORT_ARB -- requirements
Module: port_arb

---
 rtl/port_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 32 +++
 rtl/port_arb.sv | 153 +++++++++++++++
 tb/tb_port_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/port_arb_pkg.sv
// Shared constants and types for the output-port arbiter.
package port_arb_pkg;

  localparam int unsigned NumPorts = 5;

  // Port index and flit type field widths (fields are WIDTH+1 bits).
  localparam int unsigned PORTW = 2;
  localparam int unsigned TYPEW = 1;

  localparam logic [TYPEW:0] TYPE_HEAD     = 2'd0;
  localparam logic [TYPEW:0] TYPE_BODY     = 2'd1;
  localparam logic [TYPEW:0] TYPE_TAIL     = 2'd2;
  localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'd3;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Next input index with wrap 4 -> 0.
  function automatic logic [2:0] rr_next(input logic [2:0] idx);
    return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first eligible input at or after ptr_i, wrapping 4 -> 0.
module rr_pick
  import port_arb_pkg::*;
(
  input  logic [NumPorts-1:0] elig_i,
  input  logic [2:0]          ptr_i,
  output logic                found_o,
  output logic [2:0]          winner_o
);

  logic [3:0] idx;
  logic       hit;

  // Scan the five candidates in priority order starting at the pointer.
  always_comb begin
    idx      = '0;
    hit      = 1'b0;
    winner_o = '0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = {1'b0, ptr_i} + 4'(k);
      if (idx >= 4'd5) begin
        idx = idx - 4'd5;
      end
      if (!hit && elig_i[idx]) begin
        hit      = 1'b1;
        winner_o = idx[2:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/port_arb.sv
// Wormhole output-port arbiter: round-robin grant, held until the owner's tail flit.
module port_arb
  import port_arb_pkg::*;
#(
  parameter int unsigned PORTID   = 0,
  parameter int unsigned ROUTERID = 0  // debug tag only
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           req_0,
  input  logic           req_1,
  input  logic           req_2,
  input  logic           req_3,
  input  logic           req_4,
  input  logic [PORTW:0] port_0,
  input  logic [PORTW:0] port_1,
  input  logic [PORTW:0] port_2,
  input  logic [PORTW:0] port_3,
  input  logic [PORTW:0] port_4,
  input  logic           ivalid_0,
  input  logic           ivalid_1,
  input  logic           ivalid_2,
  input  logic           ivalid_3,
  input  logic           ivalid_4,
  input  logic [TYPEW:0] itype_0,
  input  logic [TYPEW:0] itype_1,
  input  logic [TYPEW:0] itype_2,
  input  logic [TYPEW:0] itype_3,
  input  logic [TYPEW:0] itype_4,
  output logic           grt_0,
  output logic           grt_1,
  output logic           grt_2,
  output logic           grt_3,
  output logic           grt_4,
  output logic [2:0]     owner,
  output logic           busy
);

  localparam logic [PORTW:0] PortSel = PORTID[PORTW:0];

  arb_state_e          state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          rr_q, rr_d;
  logic [NumPorts-1:0] grt_q, grt_d;
  logic                busy_q, busy_d;

  logic [NumPorts-1:0] req_v, ivalid_v, elig;
  logic [PORTW:0]      port_v  [NumPorts];
  logic [TYPEW:0]      itype_v [NumPorts];

  logic [NumPorts-1:0] pick_mask;
  logic [2:0]          pick_ptr;
  logic                pick_found;
  logic [2:0]          pick_winner;
  logic                own_tail, tail_rel;

  assign req_v    = {req_4, req_3, req_2, req_1, req_0};
  assign ivalid_v = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign port_v   = '{port_0, port_1, port_2, port_3, port_4};
  assign itype_v  = '{itype_0, itype_1, itype_2, itype_3, itype_4};

  // An input competes only when it requests and targets this port.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumPorts; i++) begin
      elig[i] = (req_v[i] == Enable) && (port_v[i] == PortSel);
    end
  end

  // Only the owner's tail flit ends the packet; other inputs' flits are ignored.
  assign own_tail = ivalid_v[owner_q] &&
                    ((itype_v[owner_q] == TYPE_TAIL) || (itype_v[owner_q] == TYPE_HEADTAIL));
  assign tail_rel = (state_q == ArbLocked) && own_tail;

  // On release the outgoing owner is excluded and the search starts just past it.
  always_comb begin
    pick_mask = elig;
    pick_ptr  = rr_q;
    if (state_q == ArbLocked) begin
      pick_mask = elig & ~(5'b00001 << owner_q);
      pick_ptr  = rr_next(owner_q);
    end
  end

  rr_pick u_rr_pick (
    .elig_i   (pick_mask),
    .ptr_i    (pick_ptr),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // Next-state and next-output logic; default is to hold everything.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grt_d   = grt_q;
    busy_d  = busy_q;
    unique case (state_q)
      ArbIdle: begin
        if (pick_found) begin
          state_d = ArbLocked;
          owner_d = pick_winner;
          grt_d   = 5'b00001 << pick_winner;
          busy_d  = 1'b1;
        end
      end
      ArbLocked: begin
        if (tail_rel) begin
          rr_d = rr_next(owner_q);
          if (pick_found) begin
            owner_d = pick_winner;
            grt_d   = 5'b00001 << pick_winner;
          end else begin
            state_d = ArbIdle;
            owner_d = '0;
            grt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ArbIdle;
      owner_q <= '0;
      rr_q    <= '0;
      grt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grt_q   <= grt_d;
      busy_q  <= busy_d;
    end
  end

  assign grt_0 = grt_q[0];
  assign grt_1 = grt_q[1];
  assign grt_2 = grt_q[2];
  assign grt_3 = grt_q[3];
  assign grt_4 = grt_q[4];
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_port_arb.sv
// Directed bench for port_arb owning output port 2.
module tb_port_arb;
  import port_arb_pkg::*;

  localparam int unsigned Pid = 2;
  localparam logic [PORTW:0] Me    = 3'd2;
  localparam logic [PORTW:0] Other = 3'd0;

  logic           clk;
  logic           rst_;
  logic           req_0, req_1, req_2, req_3, req_4;
  logic [PORTW:0] port_0, port_1, port_2, port_3, port_4;
  logic           ivalid_0, ivalid_1, ivalid_2, ivalid_3, ivalid_4;
  logic [TYPEW:0] itype_0, itype_1, itype_2, itype_3, itype_4;
  logic           grt_0, grt_1, grt_2, grt_3, grt_4;
  logic [2:0]     owner;
  logic           busy;
  logic [4:0]     grt;

  int checks = 0;
  int errors = 0;

  assign grt = {grt_4, grt_3, grt_2, grt_1, grt_0};

  port_arb #(
    .PORTID   (Pid),
    .ROUTERID (7)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req_0    (req_0),
    .req_1    (req_1),
    .req_2    (req_2),
    .req_3    (req_3),
    .req_4    (req_4),
    .port_0   (port_0),
    .port_1   (port_1),
    .port_2   (port_2),
    .port_3   (port_3),
    .port_4   (port_4),
    .ivalid_0 (ivalid_0),
    .ivalid_1 (ivalid_1),
    .ivalid_2 (ivalid_2),
    .ivalid_3 (ivalid_3),
    .ivalid_4 (ivalid_4),
    .itype_0  (itype_0),
    .itype_1  (itype_1),
    .itype_2  (itype_2),
    .itype_3  (itype_3),
    .itype_4  (itype_4),
    .grt_0    (grt_0),
    .grt_1    (grt_1),
    .grt_2    (grt_2),
    .grt_3    (grt_3),
    .grt_4    (grt_4),
    .owner    (owner),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {req_0, req_1, req_2, req_3, req_4} = '0;
    {ivalid_0, ivalid_1, ivalid_2, ivalid_3, ivalid_4} = '0;
    port_0 = Other; port_1 = Other; port_2 = Other; port_3 = Other; port_4 = Other;
    itype_0 = TYPE_BODY; itype_1 = TYPE_BODY; itype_2 = TYPE_BODY;
    itype_3 = TYPE_BODY; itype_4 = TYPE_BODY;
  endtask

  initial begin
    int exp_order [6];
    exp_order = '{0, 1, 4, 0, 1, 4};
    clear_inputs();
    rst_ = 1'b0;
    tick();
    check("reset_grt", 32'(grt), 32'h0);
    check("reset_owner", 32'(owner), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single head on input 2, exactly one cycle of latency.
    rst_ = 1'b1;
    req_2 = Enable; port_2 = Me;
    #1;
    check("head_no_comb_path", 32'(grt), 32'h0);
    tick();
    check("head_grt", 32'(grt), 32'b00100);
    check("head_owner", 32'(owner), 32'd2);
    check("head_busy", 32'(busy), 32'h1);

    // Lock hold with request dropped and body flits.
    req_2 = Disable; ivalid_2 = 1'b1; itype_2 = TYPE_BODY;
    tick();
    check("hold_grt_a", 32'(grt), 32'b00100);
    tick();
    check("hold_grt_b", 32'(grt), 32'b00100);
    itype_2 = TYPE_TAIL;
    tick();
    check("tail_grt", 32'(grt), 32'h0);
    check("tail_busy", 32'(busy), 32'h0);
    check("tail_rr", 32'(dut.rr_q), 32'd3);
    clear_inputs();

    // Foreign traffic: input 1 owns; input 3 targets another port and sends a tail.
    req_1 = Enable; port_1 = Me;
    tick();
    check("foreign_grant", 32'(grt), 32'b00010);
    req_3 = Enable; port_3 = Other; ivalid_3 = 1'b1; itype_3 = TYPE_TAIL;
    tick();
    check("foreign_hold_a", 32'(grt), 32'b00010);
    tick();
    check("foreign_hold_b", 32'(owner), 32'd1);
    req_1 = Disable; ivalid_1 = 1'b1; itype_1 = TYPE_TAIL;
    tick();
    check("foreign_release", 32'(grt), 32'h0);
    check("foreign_rr", 32'(dut.rr_q), 32'd2);
    clear_inputs();

    // Owner 4 tails while input 0 waits: handover on the same edge.
    req_4 = Enable; port_4 = Me;
    tick();
    check("own4_grt", 32'(grt), 32'b10000);
    req_4 = Disable; ivalid_4 = 1'b1; itype_4 = TYPE_TAIL;
    req_0 = Enable; port_0 = Me;
    tick();
    check("handover_grt", 32'(grt), 32'b00001);
    check("handover_busy", 32'(busy), 32'h1);
    check("handover_rr", 32'(dut.rr_q), 32'd0);
    clear_inputs();
    ivalid_0 = 1'b1; itype_0 = TYPE_HEADTAIL;
    tick();
    check("ht_release_grt", 32'(grt), 32'h0);
    check("ht_release_rr", 32'(dut.rr_q), 32'd1);
    clear_inputs();

    // Reset mid-packet, then the next search must start at input 0.
    req_3 = Enable; port_3 = Me;
    tick();
    check("pre_reset_owner", 32'(owner), 32'd3);
    req_3 = Disable;
    rst_ = 1'b0;
    tick();
    check("midreset_grt", 32'(grt), 32'h0);
    check("midreset_owner", 32'(owner), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    rst_ = 1'b1;
    req_0 = Enable; port_0 = Me; req_4 = Enable; port_4 = Me;
    tick();
    check("post_reset_grant", 32'(grt), 32'b00001);
    clear_inputs();
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;

    // Fairness: 0, 1, 4 request continuously, every packet is one HEADTAIL flit.
    req_0 = Enable; port_0 = Me;
    req_1 = Enable; port_1 = Me;
    req_4 = Enable; port_4 = Me;
    {ivalid_0, ivalid_1, ivalid_2, ivalid_3, ivalid_4} = '1;
    itype_0 = TYPE_HEADTAIL; itype_1 = TYPE_HEADTAIL; itype_2 = TYPE_HEADTAIL;
    itype_3 = TYPE_HEADTAIL; itype_4 = TYPE_HEADTAIL;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr_grant_%0d", i), 32'(grt), 32'(5'b00001 << exp_order[i]));
      check($sformatf("rr_busy_%0d", i), 32'(busy), 32'h1);
    end
    {req_0, req_1, req_2, req_3, req_4} = '0;
    tick();
    check("rr_drain_busy", 32'(busy), 32'h0);
    check("rr_drain_grt", 32'(grt), 32'h0);
    check("rr_drain_ptr", 32'(dut.rr_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
